// File: rtl/booth_mult_seq.sv
// Radix-2 Booth sequential multiplier with built-in IDLE/CALC/DONE control and valid/ready handshakes.
// Optional macro BOOTH_SIGN_MODE_EN adds an is_signed input for unsigned products.
module booth_mult_seq #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef BOOTH_SIGN_MODE_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   y,
  output logic             busy,
  output logic [1:0]       q_lsb
);

`ifdef BOOTH_SIGN_MODE_EN
  // Unsigned operands are zero-extended by one bit, so Q and the accumulator grow by one.
  localparam int QW = N + 1;
`else
  localparam int QW = N;
`endif
  localparam int AW = QW + 1;
  localparam int CW = $clog2(N + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  m;
  logic [QW-1:0]  q;
  logic           q_m1;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] y_q;

  logic [AW-1:0]  m_load;
  logic [QW-1:0]  q_load;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  acc_nxt;
  logic [QW-1:0]  q_nxt;
  logic [2*N-1:0] prod;
  logic [CW-1:0]  last_cnt;

`ifdef BOOTH_SIGN_MODE_EN
  logic signed_mode;

  assign m_load   = is_signed ? {{2{a[N-1]}}, a} : {2'b00, a};
  assign q_load   = is_signed ? {b[N-1], b}      : {1'b0, b};
  assign last_cnt = signed_mode ? CW'(N - 1) : CW'(N);
  // Signed runs stop one shift short, so the product sits one bit higher in {A,Q}.
  assign prod     = signed_mode ? {acc_nxt[N-1:0], q_nxt[QW-1:1]}
                                : {acc_nxt[N-2:0], q_nxt};
`else
  assign m_load   = {a[N-1], a};
  assign q_load   = b;
  assign last_cnt = CW'(N - 1);
  assign prod     = {acc_nxt[N-1:0], q_nxt};
`endif

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift right of {sum, Q, Q_-1}; the dropped Q[0] becomes the next Q_-1.
  assign acc_nxt = {sum[AW-1], sum[AW-1:1]};
  assign q_nxt   = {sum[0], q[QW-1:1]};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are plain flops, not a memory, so they are cleared with the FSM.
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      y_q   <= '0;
`ifdef BOOTH_SIGN_MODE_EN
      signed_mode <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= m_load;
            q     <= q_load;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            state <= CALC;
`ifdef BOOTH_SIGN_MODE_EN
            signed_mode <= is_signed;
`endif
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= q[0];
          cnt  <= cnt + CW'(1);
          if (cnt == last_cnt) begin
            y_q   <= prod;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);
  assign y         = y_q;
  assign q_lsb     = {q[0], q_m1};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: vector table plus backpressure, mid-run reset and operand-change sequences.
// The unsigned-mode sequence is compiled in only when BOOTH_SIGN_MODE_EN is defined.
module tb_booth_mult_seq;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] y;
  logic           busy;
  logic [1:0]     q_lsb;
`ifdef BOOTH_SIGN_MODE_EN
  logic           is_signed = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] y;
  } vec_t;

  vec_t vecs[10];

  booth_mult_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef BOOTH_SIGN_MODE_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy),
    .q_lsb     (q_lsb)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present operands, wait for accept, count cycles to out_valid, then release with out_ready=1.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                       input logic [2*N-1:0] ey, input int elat, input string nm);
    int wait_cyc;
    int lat;
    @(negedge clk);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 100) check({nm, "_accept_timeout"}, 32'(wait_cyc), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_q_lsb"}, 32'(q_lsb), 32'({tb_v[0], 1'b0}));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(elat));
    check({nm, "_y"}, 32'(y), 32'(ey));
    @(posedge clk);
    #1;
    check({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({nm, "_y_held"}, 32'(y), 32'(ey));
  endtask

  initial begin
    vecs[0] = '{8'd3,    8'd5,    16'h000F};
    vecs[1] = '{8'h80,   8'h80,   16'h4000};
    vecs[2] = '{8'hFF,   8'h7F,   16'hFF81};
    vecs[3] = '{8'h7F,   8'h80,   16'hC080};
    vecs[4] = '{8'h00,   8'hB3,   16'h0000};
    vecs[5] = '{8'hFB,   8'hF9,   16'h0023};
    vecs[6] = '{8'd100,  8'd100,  16'h2710};
    vecs[7] = '{8'h80,   8'h7F,   16'hC080};
    vecs[8] = '{8'h01,   8'hFF,   16'hFFFF};
    vecs[9] = '{8'h7F,   8'h7F,   16'h3F01};

    // Reset state while rst is held low
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_y",         32'(y),         32'd0);
    check("rst_q_lsb",     32'(q_lsb),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].y, N, $sformatf("vec%0d", i));
    end

    // Operand change during CALC: a/b are forced to 0 right after accept inside do_op
    do_op(8'd12, 8'd11, 16'h0084, N, "opchg");

    // Backpressure: -3 x 4 held in DONE while a 9 x 9 request waits
    begin
      int lat;
      out_ready = 1'b0;
      @(negedge clk);
      a = 8'hFD;
      b = 8'd4;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 8'd9;
      b = 8'd9;
      check("bp_busy", 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("bp_latency", 32'(lat), 32'(N));
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check($sformatf("bp_hold%0d_y", i),         32'(y),         32'hFFF4);
        check($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("bp_hold%0d_in_ready", i),  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_in_ready",  32'(in_ready),  32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("bp_second_accept", 32'(busy), 32'd1);
      in_valid = 1'b0;
      a = '0;
      b = '0;
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("bp_second_latency", 32'(lat), 32'(N));
      check("bp_second_y",       32'(y),   32'h0051);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the 4th CALC cycle of 100 x 100
    @(negedge clk);
    a = 8'd100;
    b = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y",         32'(y),         32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_q_lsb",     32'(q_lsb),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_result", 32'(out_valid), 32'd0);
    do_op(8'd7, 8'hFA, 16'hFFD6, N, "post_rst");

`ifdef BOOTH_SIGN_MODE_EN
    is_signed = 1'b0;
    do_op(8'hFF, 8'hFF, 16'hFE01, N + 1, "unsigned_ff");
    is_signed = 1'b1;
    do_op(8'hFF, 8'hFF, 16'h0001, N, "signed_ff");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
